// File: rtl/sr_arbiter_if.sv
// Requester/driver-side handshake bundle for sr_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface sr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned OW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   i_req;
  logic [8*NUM_REQ-1:0] i_data;
  logic [NUM_REQ-1:0]   o_ack;
  logic [NUM_REQ-1:0]   o_done;
  logic [7:0]           o_sr_data;
  logic                 o_sr_en;
  logic                 i_sr_rdy;
  logic [OW-1:0]        o_owner;
  logic                 o_busy;
  logic                 o_timeout;

  modport slave (
    input  i_req, i_data, i_sr_rdy,
    output o_ack, o_done, o_sr_data, o_sr_en, o_owner, o_busy, o_timeout
  );

  modport master (
    output i_req, i_data, i_sr_rdy,
    input  o_ack, o_done, o_sr_data, o_sr_en, o_owner, o_busy, o_timeout
  );
endinterface

// File: rtl/sr_arbiter.sv
// Round-robin arbiter sharing one serial ShiftReg driver between NUM_REQ requesters,
// sequencing issue / busy / completion / inter-frame gap with a busy-timeout.
module sr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  sr_arbiter_if.slave  bus
);
  localparam int unsigned OW       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned GW       = (GAP_LAST > 1) ? $clog2(GAP_LAST + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [OW-1:0]       r_ptr;
  logic [7:0]          r_to_cnt;
  logic [GW-1:0]       r_gap_cnt;
  logic [NUM_REQ-1:0]  r_ack;
  logic [NUM_REQ-1:0]  r_done;
  logic [7:0]          r_sr_data;
  logic                r_sr_en;
  logic [OW-1:0]       r_owner;
  logic                r_busy;
  logic                r_timeout;

  logic                w_found;
  logic [OW-1:0]       w_winner;
  logic [7:0]          w_data;
  logic [OW-1:0]       w_ptr_next;

  // Two passes: requesters at or above the pointer first, then the wrapped-around ones.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_data   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.i_req[k] && (k >= 32'(r_ptr))) begin
        w_found  = 1'b1;
        w_winner = OW'(k);
        w_data   = bus.i_data[8*k +: 8];
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.i_req[k] && (k < 32'(r_ptr))) begin
        w_found  = 1'b1;
        w_winner = OW'(k);
        w_data   = bus.i_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_ptr_next = '0;
    if (w_winner != OW'(NUM_REQ - 1)) begin
      w_ptr_next = w_winner + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
      r_ack     <= '0;
      r_done    <= '0;
      r_sr_data <= '0;
      r_sr_en   <= 1'b0;
      r_owner   <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_sr_en   <= 1'b0;
      r_ack     <= '0;
      r_done    <= '0;
      r_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.i_sr_rdy && w_found) begin
            r_sr_data        <= w_data;
            r_owner          <= w_winner;
            r_sr_en          <= 1'b1;
            r_ack[w_winner]  <= 1'b1;
            r_ptr            <= w_ptr_next;
            r_busy           <= 1'b1;
            r_state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!bus.i_sr_rdy) begin
            r_state <= S_WAIT_HIGH;
          end else if (r_to_cnt == 8'(TIMEOUT)) begin
            // Driver never went busy: abort without reporting completion.
            r_timeout <= 1'b1;
            if (GAP_CYCLES == 0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end
        S_WAIT_HIGH: begin
          if (bus.i_sr_rdy) begin
            r_done[r_owner] <= 1'b1;
            if (GAP_CYCLES == 0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GW'(GAP_LAST)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ack     = r_ack;
  assign bus.o_done    = r_done;
  assign bus.o_sr_data = r_sr_data;
  assign bus.o_sr_en   = r_sr_en;
  assign bus.o_owner   = r_owner;
  assign bus.o_busy    = r_busy;
  assign bus.o_timeout = r_timeout;
endmodule

// File: tb/tb_sr_arbiter.sv
// Directed bench for sr_arbiter: table of grant vectors plus hand-written
// timeout, not-ready and mid-transfer reset sequences, with a ShiftReg busy model.
module tb_sr_arbiter;
  localparam int unsigned NR  = 4;
  localparam int unsigned TO  = 10;
  localparam int unsigned GAP = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sr_arbiter_if #(.NUM_REQ(NR)) bus ();

  sr_arbiter #(
    .NUM_REQ   (NR),
    .TIMEOUT   (TO),
    .GAP_CYCLES(GAP)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.o_busy && n < 100) begin
      step();
      n++;
    end
    chk("idle_wait_bound", 32'(n < 100), 32'd1);
  endtask

  task automatic wait_done(input logic [3:0] exp);
    int n = 0;
    while (bus.o_done == 4'b0 && n < 40) begin
      step();
      n++;
    end
    chk("done_pulse", 32'(bus.o_done), 32'(exp));
  endtask

  // ShiftReg model: sees the enable pulse, goes busy, returns ready 4 cycles later.
  bit model_on = 1'b0;
  int busy_cnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (model_on) begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) bus.i_sr_rdy = 1'b1;
        end else if (bus.o_sr_en) begin
          bus.i_sr_rdy = 1'b0;
          busy_cnt = 4;
        end
      end
    end
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic [7:0]  sr_data;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [31:0] d0;
    logic [31:0] d1;
    int          n;
    bit          saw_done;
    d0 = 32'h13121110;
    d1 = 32'h13A51110;
    tbl[0]  = '{4'b1111, d0, 4'b0001, 2'd0, 8'h10};
    tbl[1]  = '{4'b1111, d0, 4'b0010, 2'd1, 8'h11};
    tbl[2]  = '{4'b1111, d0, 4'b0100, 2'd2, 8'h12};
    tbl[3]  = '{4'b1111, d0, 4'b1000, 2'd3, 8'h13};
    tbl[4]  = '{4'b1111, d0, 4'b0001, 2'd0, 8'h10};
    tbl[5]  = '{4'b1111, d0, 4'b0010, 2'd1, 8'h11};
    tbl[6]  = '{4'b0100, d1, 4'b0100, 2'd2, 8'hA5};
    tbl[7]  = '{4'b1111, d0, 4'b1000, 2'd3, 8'h13};
    tbl[8]  = '{4'b1001, d0, 4'b0001, 2'd0, 8'h10};
    tbl[9]  = '{4'b1001, d0, 4'b1000, 2'd3, 8'h13};
    tbl[10] = '{4'b0010, d0, 4'b0010, 2'd1, 8'h11};
    tbl[11] = '{4'b1100, d0, 4'b0100, 2'd2, 8'h12};
    tbl[12] = '{4'b1010, d0, 4'b1000, 2'd3, 8'h13};
    tbl[13] = '{4'b0001, d0, 4'b0001, 2'd0, 8'h10};
    tbl[14] = '{4'b0110, d0, 4'b0010, 2'd1, 8'h11};

    bus.i_req    = '0;
    bus.i_data   = '0;
    bus.i_sr_rdy = 1'b1;
    rst_n        = 1'b0;
    repeat (3) step();
    chk("rst_ack",     32'(bus.o_ack),     32'd0);
    chk("rst_done",    32'(bus.o_done),    32'd0);
    chk("rst_sr_data", 32'(bus.o_sr_data), 32'd0);
    chk("rst_sr_en",   32'(bus.o_sr_en),   32'd0);
    chk("rst_owner",   32'(bus.o_owner),   32'd0);
    chk("rst_busy",    32'(bus.o_busy),    32'd0);
    chk("rst_timeout", 32'(bus.o_timeout), 32'd0);
    rst_n    = 1'b1;
    model_on = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      bus.i_req  = tbl[i].req;
      bus.i_data = tbl[i].data;
      wait_idle();
      step();
      chk("grant_sr_en",   32'(bus.o_sr_en),   32'd1);
      chk("grant_ack",     32'(bus.o_ack),     32'(tbl[i].ack));
      chk("grant_owner",   32'(bus.o_owner),   32'(tbl[i].owner));
      chk("grant_sr_data", 32'(bus.o_sr_data), 32'(tbl[i].sr_data));
      step();
      chk("issue_sr_en",   32'(bus.o_sr_en),   32'd0);
      chk("issue_ack",     32'(bus.o_ack),     32'd0);
      wait_done(tbl[i].ack);
      chk("done_no_timeout", 32'(bus.o_timeout), 32'd0);
      chk("hold_sr_data",  32'(bus.o_sr_data), 32'(tbl[i].sr_data));
      step();
      chk("gap_busy",      32'(bus.o_busy),    32'd1);
      chk("done_one_cycle", 32'(bus.o_done),   32'd0);
      step();
      chk("gap_end_idle",  32'(bus.o_busy),    32'd0);
    end

    // Busy-timeout: driver stays ready, never acknowledges.
    model_on     = 1'b0;
    busy_cnt     = 0;
    bus.i_sr_rdy = 1'b1;
    bus.i_req    = 4'b0001;
    wait_idle();
    step();
    chk("to_grant_ack", 32'(bus.o_ack), 32'b0001);
    bus.i_req = '0;
    n = 0;
    saw_done = 1'b0;
    while (!bus.o_timeout && n < 100) begin
      step();
      n++;
      if (bus.o_done != 4'b0) saw_done = 1'b1;
    end
    chk("timeout_latency", 32'(n), 32'(TO + 2));
    chk("timeout_no_done", 32'(saw_done), 32'd0);
    step();
    chk("timeout_one_cycle", 32'(bus.o_timeout), 32'd0);
    model_on  = 1'b1;
    bus.i_req = 4'b0010;
    wait_idle();
    step();
    chk("after_to_ack",   32'(bus.o_ack),   32'b0010);
    chk("after_to_owner", 32'(bus.o_owner), 32'd1);
    bus.i_req = '0;
    wait_done(4'b0010);

    // Driver not ready in IDLE: no grant until ready returns.
    wait_idle();
    model_on     = 1'b0;
    bus.i_sr_rdy = 1'b0;
    bus.i_req    = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("notrdy_no_en", 32'(bus.o_sr_en), 32'd0);
    end
    chk("notrdy_idle", 32'(bus.o_busy), 32'd0);
    bus.i_sr_rdy = 1'b1;
    model_on     = 1'b1;
    step();
    chk("rdy_grant_en",  32'(bus.o_sr_en), 32'd1);
    chk("rdy_grant_ack", 32'(bus.o_ack),   32'b0001);
    bus.i_req = '0;
    wait_done(4'b0001);

    // Reset during WAIT_HIGH abandons the transfer and clears the pointer.
    wait_idle();
    bus.i_req = 4'b1111;
    step();
    chk("mid_grant_owner", 32'(bus.o_owner), 32'd1);
    step();
    step();
    chk("mid_busy", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy",    32'(bus.o_busy),    32'd0);
    chk("mid_rst_done",    32'(bus.o_done),    32'd0);
    chk("mid_rst_owner",   32'(bus.o_owner),   32'd0);
    chk("mid_rst_sr_data", 32'(bus.o_sr_data), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mid_rst_hold_done",    32'(bus.o_done),    32'd0);
      chk("mid_rst_hold_timeout", 32'(bus.o_timeout), 32'd0);
    end
    rst_n = 1'b1;
    step();
    chk("post_rst_ack",     32'(bus.o_ack),     32'b0001);
    chk("post_rst_sr_data", 32'(bus.o_sr_data), 32'h10);
    bus.i_req = '0;
    wait_done(4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sr_arbiter.md
Name: sr_arbiter

Overview:
- Round-robin arbiter that shares one 8-bit serial shift-register driver (ShiftReg) between NUM_REQ independent requesters.
- Sits between the requesters (control/pattern generators) and ShiftReg's i_Data/i_Enable/o_Ready handshake.
- Sequences each transfer: issue, wait for busy, wait for completion, enforce inter-frame gap.
- Recovers from a driver that never acknowledges by using a busy-timeout.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- TIMEOUT, 64, max cycles to wait for i_sr_rdy to go low after issue; legal range 2..255.
- GAP_CYCLES, 2, idle cycles enforced after each completed transfer before the next arbitration; 0 is legal.

Ports:
- i_clk  in  1  system clock (48 MHz HFOSC domain).
- i_rst_n  in  1  synchronous active-low reset.
- i_req  in  NUM_REQ  level request per requester; held high with stable data until o_ack.
- i_data  in  8*NUM_REQ  byte for requester k on bits [8k+7:8k].
- o_ack  out  NUM_REQ  one-cycle pulse: requester k's byte captured and issued.
- o_done  out  NUM_REQ  one-cycle pulse: requester k's transfer completed by driver.
- o_sr_data  out  8  byte to ShiftReg i_Data.
- o_sr_en  out  1  one-cycle enable pulse to ShiftReg i_Enable.
- i_sr_rdy  in  1  ShiftReg o_Ready: high = idle/able to accept, low = shifting.
- o_owner  out  OW  index of current/last granted requester, OW = max(1, clog2(NUM_REQ)).
- o_busy  out  1  high in every state except IDLE.
- o_timeout  out  1  one-cycle pulse when busy-timeout aborts a transfer.

Behaviour:
- Reset (i_rst_n low at a rising edge), applied regardless of state:
  - state = IDLE; round-robin pointer = 0; timeout and gap counters = 0.
  - All outputs = 0 (o_sr_data = 8'h00, o_owner = 0).
  - A transfer in progress is abandoned: no o_done, no o_timeout.
- All outputs are registered.
- IDLE:
  - Arbitrates only when i_sr_rdy = 1 and |i_req = 1; otherwise stays in IDLE.
  - Winner is the first requester with i_req set, scanning from the pointer upward with wrap-around.
- Grant (edge after the winning IDLE cycle):
  - o_sr_data = i_data byte of the winner; o_owner = winner.
  - o_sr_en = 1 and o_ack[winner] = 1, both for exactly one cycle.
  - Pointer = (winner + 1) mod NUM_REQ; state goes to ISSUE.
  - Latency from request seen in IDLE to o_sr_en: 1 cycle.
- ISSUE (1 cycle):
  - o_sr_en returns to 0; timeout counter cleared; state goes to WAIT_LOW.
  - i_sr_rdy is ignored in this cycle.
- WAIT_LOW:
  - If i_sr_rdy = 0, go to WAIT_HIGH.
  - Otherwise increment the counter; when the count reaches TIMEOUT, pulse o_timeout, skip o_done, and go to GAP.
- WAIT_HIGH:
  - Waits indefinitely for i_sr_rdy = 1.
  - Then pulses o_done[o_owner] for one cycle and goes to GAP.
- GAP:
  - Counts GAP_CYCLES cycles, then goes to IDLE; with GAP_CYCLES = 0 it goes directly to IDLE.
  - Requests arriving during GAP are held pending by the requester and never lost.
- Simultaneous requests: resolved purely by the pointer.
  - With all requesters permanently active, grant order is 0,1,2,…,NUM_REQ-1,0 (no starvation).
- Request dropped before o_ack: it is simply not considered at the next IDLE arbitration. No partial state is kept.
- o_sr_data holds its value after o_sr_en until the next grant.
- o_ack and o_done are never asserted for more than one requester in the same cycle.

Test Plan:
1. Single requester: reset, i_req = 4'b0100, i_data[23:16] = 8'hA5, i_sr_rdy driven by a ShiftReg model -> o_sr_en pulse 1 cycle after request, o_sr_data = 8'hA5, o_ack = 4'b0100, o_owner = 2; o_done = 4'b0100 when rdy returns high; o_busy low after GAP_CYCLES.
2. Contention: i_req = 4'b1111 held continuously, each data = 8'h10+k -> o_ack sequence 0,1,2,3,0,1; o_sr_data sequence 10,11,12,13,10,11; no requester granted twice in a row.
3. Pointer wrap: after a grant to 3, raise i_req = 4'b1001 -> next grant goes to 0, then 3.
4. Timeout: i_sr_rdy held high permanently, one request issued -> o_timeout pulses exactly TIMEOUT+2 cycles after o_sr_en, no o_done; arbiter returns to IDLE and grants the next request normally.
5. Driver not ready: i_sr_rdy = 0 in IDLE with i_req = 4'b0001 -> no o_sr_en until rdy = 1; grant follows 1 cycle later.
6. Reset mid-transfer: assert i_rst_n = 0 during WAIT_HIGH -> next cycle o_busy = 0, o_done = 0, pointer = 0; after release with i_req = 4'b1111, first grant goes to 0.
